// File: rtl/ddr4_v2_2_20_mc_ecc_rmw_ctrl_if.sv
// ddr4_v2_2_20_mc_ecc_rmw_ctrl_if
// Bundles every non-clock signal of the ECC read-modify-write sequencer.
//   request side   : req_valid/req_ready, req_addr, req_buf_addr, req_partial
//   read command   : rd_cmd_valid/rd_cmd_ready, rd_cmd_addr
//   read return    : rd_data_valid, rd_data_ue
//   merge/encode   : merge_en, merge_buf_addr, raw_not_ecc
//   write command  : wr_cmd_valid/wr_cmd_ready, wr_cmd_addr, wr_cmd_buf_addr
//   status         : rmw_abort, rmw_ue_cnt
// Modports: slave = the sequencer, master = the surrounding MC logic.
//
// Handshakes (req, rd_cmd, wr_cmd): a transfer happens on a rising clock
// edge where valid and ready are both 1. Once valid is raised it stays high
// and its payload stays unchanged until that transfer; ready may stay low
// for any number of cycles and carries no obligation.
interface ddr4_v2_2_20_mc_ecc_rmw_ctrl_if #(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_BUF_ADDR_WIDTH = 5,
  parameter int nCK_PER_CLK         = 4
);
  logic                           req_valid;
  logic                           req_ready;
  logic [ADDR_WIDTH-1:0]          req_addr;
  logic [DATA_BUF_ADDR_WIDTH-1:0] req_buf_addr;
  logic                           req_partial;
  logic                           rd_cmd_valid;
  logic                           rd_cmd_ready;
  logic [ADDR_WIDTH-1:0]          rd_cmd_addr;
  logic                           rd_data_valid;
  logic                           rd_data_ue;
  logic                           merge_en;
  logic [DATA_BUF_ADDR_WIDTH-1:0] merge_buf_addr;
  logic [2*nCK_PER_CLK-1:0]       raw_not_ecc;
  logic                           wr_cmd_valid;
  logic                           wr_cmd_ready;
  logic [ADDR_WIDTH-1:0]          wr_cmd_addr;
  logic [DATA_BUF_ADDR_WIDTH-1:0] wr_cmd_buf_addr;
  logic                           rmw_abort;
  logic [7:0]                     rmw_ue_cnt;

  modport slave (
    input  req_valid, req_addr, req_buf_addr, req_partial,
    output req_ready,
    output rd_cmd_valid, rd_cmd_addr,
    input  rd_cmd_ready,
    input  rd_data_valid, rd_data_ue,
    output merge_en, merge_buf_addr, raw_not_ecc,
    output wr_cmd_valid, wr_cmd_addr, wr_cmd_buf_addr,
    input  wr_cmd_ready,
    output rmw_abort, rmw_ue_cnt
  );

  modport master (
    output req_valid, req_addr, req_buf_addr, req_partial,
    input  req_ready,
    input  rd_cmd_valid, rd_cmd_addr,
    output rd_cmd_ready,
    output rd_data_valid, rd_data_ue,
    input  merge_en, merge_buf_addr, raw_not_ecc,
    input  wr_cmd_valid, wr_cmd_addr, wr_cmd_buf_addr,
    output wr_cmd_ready,
    input  rmw_abort, rmw_ue_cnt
  );
endinterface

// File: rtl/ddr4_v2_2_20_mc_ecc_rmw_ctrl.sv
// ddr4_v2_2_20_mc_ecc_rmw_ctrl
// Sequences read-modify-write for byte-masked ECC writes. Full writes go
// straight to the write-command path; partial writes read the target line,
// hold the merge buffer for MERGE_LAT cycles while merge/encode runs, then
// issue the write. One transaction in flight.
// Ports:
//   clk, rst   : fabric clock, synchronous active-high reset
//   bus        : ddr4_v2_2_20_mc_ecc_rmw_ctrl_if.slave (request, read/write
//                command, read return, merge control, status)
//   dbg_state  : current FSM state (0 IDLE, 1 RD_ISSUE, 2 RD_WAIT,
//                3 MERGE, 4 WR_ISSUE)
// Optional feature macro: DDR4_RMW_UE_POISON_EN -- when defined, a UE on the
// RMW read forces raw_not_ecc to all-ones for that write so the buffered
// check bits poison the line; otherwise raw_not_ecc is tied 0.
// All outputs are registered.
module ddr4_v2_2_20_mc_ecc_rmw_ctrl #(
  parameter int TCQ                 = 100,
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_BUF_ADDR_WIDTH = 5,
  parameter int MERGE_LAT           = 2,
  parameter int RD_TIMEOUT          = 255,
  parameter int nCK_PER_CLK         = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  ddr4_v2_2_20_mc_ecc_rmw_ctrl_if.slave         bus,
  output logic [2:0]                            dbg_state
);

  // Elaboration-time parameter sanity checks. TCQ only models clock-to-q
  // delay in behavioural sims and has no effect on this netlist.
  if (TCQ < 0) begin : g_bad_tcq
    $error("TCQ must be non-negative");
  end
  if (MERGE_LAT < 1 || MERGE_LAT > 256) begin : g_bad_merge_lat
    $error("MERGE_LAT must be 1..256");
  end
  if (RD_TIMEOUT < 1 || RD_TIMEOUT > 255) begin : g_bad_rd_timeout
    $error("RD_TIMEOUT must be 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_MERGE    = 3'd3,
    S_WR_ISSUE = 3'd4
  } state_e;

  // RD_WAIT lasts at most RD_TIMEOUT cycles; the last one sees cnt == TMO_LAST.
  localparam logic [7:0] TMO_LAST   = 8'(RD_TIMEOUT - 1);
  localparam logic [7:0] MERGE_LAST = 8'(MERGE_LAT - 1);

  state_e                         state_q, state_d;
  logic [7:0]                     tmo_cnt_q, tmo_cnt_d;
  logic [7:0]                     merge_cnt_q, merge_cnt_d;
  logic [7:0]                     ue_cnt_q, ue_cnt_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [DATA_BUF_ADDR_WIDTH-1:0] buf_q, buf_d;
  logic                           req_ready_q, req_ready_d;
  logic                           rd_cmd_valid_q, rd_cmd_valid_d;
  logic                           wr_cmd_valid_q, wr_cmd_valid_d;
  logic                           merge_en_q, merge_en_d;
  logic                           rmw_abort_q, rmw_abort_d;

  logic accept, rd_hs, wr_hs, data_in, timeout;

  assign accept  = (state_q == S_IDLE) && req_ready_q && bus.req_valid;
  assign rd_hs   = rd_cmd_valid_q && bus.rd_cmd_ready;
  assign wr_hs   = wr_cmd_valid_q && bus.wr_cmd_ready;
  // Read data arriving outside RD_WAIT is not ours and is dropped.
  assign data_in = (state_q == S_RD_WAIT) && bus.rd_data_valid;
  // Data on the final wait cycle beats the timeout.
  assign timeout = (state_q == S_RD_WAIT) && !bus.rd_data_valid &&
                   (tmo_cnt_q == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = bus.req_partial ? S_RD_ISSUE : S_WR_ISSUE;
      S_RD_ISSUE: if (rd_hs) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (data_in)      state_d = S_MERGE;
        else if (timeout) state_d = S_IDLE;
      end
      S_MERGE:    if (merge_cnt_q == MERGE_LAST) state_d = S_WR_ISSUE;
      S_WR_ISSUE: if (wr_hs) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: registered outputs follow the state being entered.
  always_comb begin
    // req_ready lags one cycle behind the return to IDLE.
    req_ready_d    = (state_q == S_IDLE) && (state_d == S_IDLE);
    rd_cmd_valid_d = (state_d == S_RD_ISSUE);
    wr_cmd_valid_d = (state_d == S_WR_ISSUE);
    // Merge pointer stays held from MERGE through the write handshake; full
    // writes enter WR_ISSUE with merge_en_q low and never raise it.
    merge_en_d     = (state_d == S_MERGE) || ((state_d == S_WR_ISSUE) && merge_en_q);
    rmw_abort_d    = timeout;
  end

  // Counters and request latches
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    merge_cnt_d = merge_cnt_q;
    ue_cnt_d    = ue_cnt_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    if (accept) begin
      addr_d = bus.req_addr;
      buf_d  = bus.req_buf_addr;
    end
    if (rd_hs)                    tmo_cnt_d = 8'd0;
    else if (state_q == S_RD_WAIT) tmo_cnt_d = tmo_cnt_q + 8'd1;
    if (data_in)                  merge_cnt_d = 8'd0;
    else if (state_q == S_MERGE)  merge_cnt_d = merge_cnt_q + 8'd1;
    if (data_in && bus.rd_data_ue && (ue_cnt_q != 8'hFF)) ue_cnt_d = ue_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q      <= '0;
      merge_cnt_q    <= '0;
      ue_cnt_q       <= '0;
      addr_q         <= '0;
      buf_q          <= '0;
      req_ready_q    <= 1'b0;
      rd_cmd_valid_q <= 1'b0;
      wr_cmd_valid_q <= 1'b0;
      merge_en_q     <= 1'b0;
      rmw_abort_q    <= 1'b0;
    end else begin
      tmo_cnt_q      <= tmo_cnt_d;
      merge_cnt_q    <= merge_cnt_d;
      ue_cnt_q       <= ue_cnt_d;
      addr_q         <= addr_d;
      buf_q          <= buf_d;
      req_ready_q    <= req_ready_d;
      rd_cmd_valid_q <= rd_cmd_valid_d;
      wr_cmd_valid_q <= wr_cmd_valid_d;
      merge_en_q     <= merge_en_d;
      rmw_abort_q    <= rmw_abort_d;
    end
  end

`ifdef DDR4_RMW_UE_POISON_EN
  logic [2*nCK_PER_CLK-1:0] raw_q, raw_d;

  // Set on a UE read return, held through the write, cleared entering IDLE.
  always_comb begin
    raw_d = raw_q;
    if (data_in && bus.rd_data_ue) raw_d = '1;
    if (state_d == S_IDLE)         raw_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) raw_q <= '0;
    else     raw_q <= raw_d;
  end

  assign bus.raw_not_ecc = raw_q;
`else
  assign bus.raw_not_ecc = '0;
`endif

  assign bus.req_ready       = req_ready_q;
  assign bus.rd_cmd_valid    = rd_cmd_valid_q;
  assign bus.rd_cmd_addr     = addr_q;
  assign bus.merge_en        = merge_en_q;
  assign bus.merge_buf_addr  = buf_q;
  assign bus.wr_cmd_valid    = wr_cmd_valid_q;
  assign bus.wr_cmd_addr     = addr_q;
  assign bus.wr_cmd_buf_addr = buf_q;
  assign bus.rmw_abort       = rmw_abort_q;
  assign bus.rmw_ue_cnt      = ue_cnt_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_ddr4_v2_2_20_mc_ecc_rmw_ctrl.sv
// Bench for ddr4_v2_2_20_mc_ecc_rmw_ctrl (RD_TIMEOUT overridden to 16).
// A per-cycle vector table covers reset exit, a full write, a partial write
// and a UE partial write with backpressure; hand sequences cover long write
// backpressure, read timeout, data on the timeout cycle, UE saturation and
// reset in the middle of a read wait.
module tb_ddr4_v2_2_20_mc_ecc_rmw_ctrl;

`ifdef DDR4_RMW_UE_POISON_EN
  localparam bit POISON = 1'b1;
`else
  localparam bit POISON = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr4_v2_2_20_mc_ecc_rmw_ctrl_if bus ();
  logic [2:0] dbg_state;

  ddr4_v2_2_20_mc_ecc_rmw_ctrl #(
    .TCQ(100), .ADDR_WIDTH(32), .DATA_BUF_ADDR_WIDTH(5),
    .MERGE_LAT(2), .RD_TIMEOUT(16), .nCK_PER_CLK(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int exp_ue = 0;

  typedef struct {
    logic rv, part;
    logic [31:0] addr;
    logic [4:0] bufa;
    logic rdr, rdv, ue, wrr;
    logic e_rr, e_rdv, e_wrv, e_men, e_ab;
    logic [2:0] e_st;
    logic [31:0] e_addr;
    logic [4:0] e_buf;
    logic [7:0] e_ue;
    logic e_pz;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int rv, part, addr, bufa, rdr, rdv, ue, wrr,
                              e_rr, e_rdv, e_wrv, e_men, e_ab, e_st,
                              e_addr, e_buf, e_ue, e_pz);
    vec_t v;
    v.rv = rv[0]; v.part = part[0]; v.addr = addr; v.bufa = bufa[4:0];
    v.rdr = rdr[0]; v.rdv = rdv[0]; v.ue = ue[0]; v.wrr = wrr[0];
    v.e_rr = e_rr[0]; v.e_rdv = e_rdv[0]; v.e_wrv = e_wrv[0];
    v.e_men = e_men[0]; v.e_ab = e_ab[0]; v.e_st = e_st[2:0];
    v.e_addr = e_addr; v.e_buf = e_buf[4:0]; v.e_ue = e_ue[7:0];
    v.e_pz = e_pz[0];
    return v;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_partial = 1'b0;
    bus.req_addr = '0; bus.req_buf_addr = '0;
    bus.rd_cmd_ready = 1'b0; bus.rd_data_valid = 1'b0;
    bus.rd_data_ue = 1'b0; bus.wr_cmd_ready = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.req_ready && n < 20) begin step(); n++; end
    check(name, 32'(bus.req_ready), 32'd1);
  endtask

  // One UE-free or UE partial write with all readies prompt.
  task automatic rmw_txn(input logic ue, input int idx);
    bus.req_valid = 1'b1; bus.req_partial = 1'b1;
    bus.req_addr = 32'h300; bus.req_buf_addr = 5'd2; bus.rd_cmd_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.rd_data_valid = 1'b1; bus.rd_data_ue = ue;
    step();
    bus.rd_data_valid = 1'b0; bus.rd_data_ue = 1'b0;
    if (ue && exp_ue < 255) exp_ue++;
    step(); step();
    check($sformatf("ue%0d_wr_valid", idx), 32'(bus.wr_cmd_valid), 32'd1);
    check($sformatf("ue%0d_raw", idx), 32'(bus.raw_not_ecc),
          (POISON && ue) ? 32'hFF : 32'h0);
    check($sformatf("ue%0d_cnt", idx), 32'(bus.rmw_ue_cnt), 32'(exp_ue));
    bus.wr_cmd_ready = 1'b1;
    step();
    bus.wr_cmd_ready = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    int n;
    vec_t v;
    idle_inputs();

    // rv part addr bufa rdr rdv ue wrr | rr rdv wrv men ab st  addr buf ue pz
    vq.push_back(mk(0,0,0,0,          0,0,0,0, 1,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(1,0,'h100,5,      0,0,0,1, 0,0,1,0,0,4, 'h100,5,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,0,0,0,0, 'h100,5,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 1,0,0,0,0,0, 'h100,5,0,0));
    vq.push_back(mk(1,1,'h40,3,       1,0,0,1, 0,1,0,0,0,1, 'h40,3,0,0));
    vq.push_back(mk(0,0,0,0,          1,0,0,1, 0,0,0,0,0,2, 'h40,3,0,0));
    vq.push_back(mk(0,0,0,0,          1,0,0,1, 0,0,0,0,0,2, 'h40,3,0,0));
    vq.push_back(mk(0,0,0,0,          1,1,0,1, 0,0,0,1,0,3, 'h40,3,0,0));
    vq.push_back(mk(0,0,0,0,          1,0,0,1, 0,0,0,1,0,3, 'h40,3,0,0));
    vq.push_back(mk(0,0,0,0,          1,0,0,1, 0,0,1,1,0,4, 'h40,3,0,0));
    vq.push_back(mk(0,0,0,0,          1,0,0,1, 0,0,0,0,0,0, 'h40,3,0,0));
    vq.push_back(mk(0,0,0,0,          1,0,0,1, 1,0,0,0,0,0, 'h40,3,0,0));
    vq.push_back(mk(0,0,0,0,          0,1,1,0, 1,0,0,0,0,0, 'h40,3,0,0));
    vq.push_back(mk(1,1,'h7C,'h1F,    0,0,0,0, 0,1,0,0,0,1, 'h7C,'h1F,0,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,0, 0,1,0,0,0,1, 'h7C,'h1F,0,0));
    vq.push_back(mk(0,0,0,0,          1,0,0,0, 0,0,0,0,0,2, 'h7C,'h1F,0,0));
    vq.push_back(mk(0,0,0,0,          0,1,1,0, 0,0,0,1,0,3, 'h7C,'h1F,1,1));
    vq.push_back(mk(0,0,0,0,          0,0,0,0, 0,0,0,1,0,3, 'h7C,'h1F,1,1));
    vq.push_back(mk(0,0,0,0,          0,0,0,0, 0,0,1,1,0,4, 'h7C,'h1F,1,1));
    vq.push_back(mk(0,0,0,0,          0,0,0,0, 0,0,1,1,0,4, 'h7C,'h1F,1,1));
    vq.push_back(mk(0,0,0,0,          0,0,0,1, 0,0,0,0,0,0, 'h7C,'h1F,1,0));
    vq.push_back(mk(0,0,0,0,          0,0,0,0, 1,0,0,0,0,0, 'h7C,'h1F,1,0));

    // Reset state
    step(); step();
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_cmd_valid), 32'd0);
    check("rst_wr_valid", 32'(bus.wr_cmd_valid), 32'd0);
    check("rst_merge_en", 32'(bus.merge_en), 32'd0);
    check("rst_ue_cnt", 32'(bus.rmw_ue_cnt), 32'd0);
    check("rst_raw", 32'(bus.raw_not_ecc), 32'd0);
    rst = 1'b0;

    // Table-driven per-cycle vectors
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      bus.req_valid = v.rv; bus.req_partial = v.part;
      bus.req_addr = v.addr; bus.req_buf_addr = v.bufa;
      bus.rd_cmd_ready = v.rdr; bus.rd_data_valid = v.rdv;
      bus.rd_data_ue = v.ue; bus.wr_cmd_ready = v.wrr;
      step();
      check($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(v.e_rr));
      check($sformatf("v%0d_rd_valid", i), 32'(bus.rd_cmd_valid), 32'(v.e_rdv));
      check($sformatf("v%0d_wr_valid", i), 32'(bus.wr_cmd_valid), 32'(v.e_wrv));
      check($sformatf("v%0d_merge_en", i), 32'(bus.merge_en), 32'(v.e_men));
      check($sformatf("v%0d_abort", i), 32'(bus.rmw_abort), 32'(v.e_ab));
      check($sformatf("v%0d_state", i), 32'(dbg_state), 32'(v.e_st));
      check($sformatf("v%0d_rd_addr", i), bus.rd_cmd_addr, v.e_addr);
      check($sformatf("v%0d_wr_addr", i), bus.wr_cmd_addr, v.e_addr);
      check($sformatf("v%0d_wr_buf", i), 32'(bus.wr_cmd_buf_addr), 32'(v.e_buf));
      check($sformatf("v%0d_merge_buf", i), 32'(bus.merge_buf_addr), 32'(v.e_buf));
      check($sformatf("v%0d_ue_cnt", i), 32'(bus.rmw_ue_cnt), 32'(v.e_ue));
      check($sformatf("v%0d_raw", i), 32'(bus.raw_not_ecc),
            (v.e_pz && POISON) ? 32'hFF : 32'h0);
    end
    idle_inputs();
    exp_ue = 1;

    // Write backpressure for 10 cycles with a new request pending
    bus.req_valid = 1'b1; bus.req_partial = 1'b1;
    bus.req_addr = 32'h1234; bus.req_buf_addr = 5'd9; bus.rd_cmd_ready = 1'b1;
    step();
    bus.req_addr = 32'hDEAD; bus.req_buf_addr = 5'd7;
    step();
    bus.rd_data_valid = 1'b1;
    step();
    bus.rd_data_valid = 1'b0;
    n = 0;
    while (!bus.wr_cmd_valid && n < 10) begin step(); n++; end
    check("bp_merge_latency", 32'(n), 32'd2);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp%0d_wr_valid", k), 32'(bus.wr_cmd_valid), 32'd1);
      check($sformatf("bp%0d_wr_addr", k), bus.wr_cmd_addr, 32'h1234);
      check($sformatf("bp%0d_wr_buf", k), 32'(bus.wr_cmd_buf_addr), 32'd9);
      check($sformatf("bp%0d_merge_en", k), 32'(bus.merge_en), 32'd1);
      check($sformatf("bp%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.req_valid = 1'b0; bus.wr_cmd_ready = 1'b1;
    step();
    bus.wr_cmd_ready = 1'b0;
    check("bp_done_state", 32'(dbg_state), 32'd0);
    check("bp_done_merge_en", 32'(bus.merge_en), 32'd0);
    wait_ready("bp_ready_back");

    // Read timeout: no data for RD_TIMEOUT cycles after the read handshake
    bus.req_valid = 1'b1; bus.req_partial = 1'b1;
    bus.req_addr = 32'h55; bus.req_buf_addr = 5'd1; bus.rd_cmd_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.rd_cmd_ready = 1'b0;
    bad = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (bus.rmw_abort || bus.wr_cmd_valid || dbg_state != 3'd2) bad = 1'b1;
    end
    check("tmo_no_early_abort", 32'(bad), 32'd0);
    step();
    check("tmo_abort", 32'(bus.rmw_abort), 32'd1);
    check("tmo_state", 32'(dbg_state), 32'd0);
    check("tmo_no_wr", 32'(bus.wr_cmd_valid), 32'd0);
    step();
    check("tmo_abort_pulse", 32'(bus.rmw_abort), 32'd0);
    check("tmo_req_ready", 32'(bus.req_ready), 32'd1);
    check("tmo_no_wr2", 32'(bus.wr_cmd_valid), 32'd0);

    // Data on the timeout cycle wins
    bus.req_valid = 1'b1; bus.req_partial = 1'b1;
    bus.req_addr = 32'h66; bus.req_buf_addr = 5'd6; bus.rd_cmd_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.rd_cmd_ready = 1'b0;
    for (int k = 1; k < 16; k++) step();
    bus.rd_data_valid = 1'b1;
    step();
    bus.rd_data_valid = 1'b0;
    check("late_data_no_abort", 32'(bus.rmw_abort), 32'd0);
    check("late_data_merge", 32'(dbg_state), 32'd3);
    check("late_data_merge_en", 32'(bus.merge_en), 32'd1);
    step(); step();
    check("late_data_wr_valid", 32'(bus.wr_cmd_valid), 32'd1);
    check("late_data_wr_addr", bus.wr_cmd_addr, 32'h66);
    bus.wr_cmd_ready = 1'b1;
    step();
    bus.wr_cmd_ready = 1'b0;
    wait_ready("late_data_ready_back");

    // UE on 300 RMW reads: count saturates at 255
    for (int k = 0; k < 300; k++) rmw_txn(1'b1, k);
    check("ue_saturated", 32'(bus.rmw_ue_cnt), 32'd255);
    rmw_txn(1'b0, 300);

    // Reset while in RD_WAIT, then stale read data
    bus.req_valid = 1'b1; bus.req_partial = 1'b1;
    bus.req_addr = 32'h77; bus.req_buf_addr = 5'd4; bus.rd_cmd_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step(); step();
    check("rstmid_in_wait", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    step();
    check("rstmid_state", 32'(dbg_state), 32'd0);
    check("rstmid_req_ready", 32'(bus.req_ready), 32'd0);
    check("rstmid_ue_cnt", 32'(bus.rmw_ue_cnt), 32'd0);
    check("rstmid_addr", bus.wr_cmd_addr, 32'd0);
    rst = 1'b0;
    bus.rd_data_valid = 1'b1;
    step();
    bus.rd_data_valid = 1'b0;
    check("rstmid_ready_back", 32'(bus.req_ready), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.merge_en || bus.wr_cmd_valid || bus.rd_cmd_valid) bad = 1'b1;
      step();
    end
    check("rstmid_no_cmds", 32'(bad), 32'd0);
    check("rstmid_ue_still0", 32'(bus.rmw_ue_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
